// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port dmem with read-return tracking.
// Define DMEM_ARB_RR_EN for round-robin ties; default is fixed priority (r0).
module dmem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_wren,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_wren,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] address_dmem,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  input  logic [DATA_W-1:0] q_dmem
);

  logic tie1;

`ifdef DMEM_ARB_RR_EN
  logic last_win;

  assign tie1 = ~last_win;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_win <= 1'b1;
    end else if (r0_gnt | r1_gnt) begin
      last_win <= r1_gnt;
    end
  end
`else
  assign tie1 = 1'b0;
`endif

  assign r0_gnt = reset & r0_req & (~r1_req | ~tie1);
  assign r1_gnt = reset & r1_req & (~r0_req | tie1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      address_dmem <= '0;
      data         <= '0;
      wren         <= 1'b0;
    end else begin
      unique case (1'b1)
        r0_gnt: begin
          address_dmem <= r0_addr;
          data         <= r0_wdata;
          wren         <= r0_wren;
        end
        r1_gnt: begin
          address_dmem <= r1_addr;
          data         <= r1_wdata;
          wren         <= r1_wren;
        end
        default: wren <= 1'b0;
      endcase
    end
  end

  // Stage RD_LAT lines up with q_dmem for the read issued RD_LAT+1 cycles ago.
  logic [RD_LAT:0] pv;
  logic [RD_LAT:0] po;
  logic            rd_issue;

  assign rd_issue = (r0_gnt & ~r0_wren) | (r1_gnt & ~r1_wren);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pv <= '0;
      po <= '0;
    end else begin
      pv <= {pv[RD_LAT-1:0], rd_issue};
      po <= {po[RD_LAT-1:0], r1_gnt};
    end
  end

  assign r0_rvalid = pv[RD_LAT] & ~po[RD_LAT];
  assign r1_rvalid = pv[RD_LAT] &  po[RD_LAT];
  assign r0_rdata  = q_dmem;
  assign r1_rdata  = q_dmem;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter with a behavioural syncram
// and a shadow-memory reference model.
module tb_dmem_arbiter;
  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int LAT = 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          r0_req = 1'b0, r0_wren = 1'b0;
  logic [AW-1:0] r0_addr = '0;
  logic [DW-1:0] r0_wdata = '0;
  logic          r0_gnt, r0_rvalid;
  logic [DW-1:0] r0_rdata;
  logic          r1_req = 1'b0, r1_wren = 1'b0;
  logic [AW-1:0] r1_addr = '0;
  logic [DW-1:0] r1_wdata = '0;
  logic          r1_gnt, r1_rvalid;
  logic [DW-1:0] r1_rdata;
  logic [AW-1:0] address_dmem;
  logic [DW-1:0] data;
  logic          wren;
  logic [DW-1:0] q_dmem;

  always #5 clock = ~clock;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
    .clock(clock), .reset(reset),
    .r0_req(r0_req), .r0_wren(r0_wren), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
    .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_wren(r1_wren), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
    .r1_rdata(r1_rdata),
    .address_dmem(address_dmem), .data(data), .wren(wren),
    .q_dmem(q_dmem)
  );

  function automatic logic [DW-1:0] init_val(int a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Environment syncram: registered read, RD_LAT cycles after the address.
  logic [DW-1:0] mem [2**AW];
  bit            mw  [2**AW];
  logic [DW-1:0] qd  [LAT];

  always @(posedge clock) begin
    if (wren) begin
      mem[address_dmem] <= data;
      mw[address_dmem]  <= 1'b1;
    end
    qd[0] <= mw[address_dmem] ? mem[address_dmem] : init_val(int'(address_dmem));
    for (int i = 1; i < LAT; i++) qd[i] <= qd[i-1];
  end

  assign q_dmem = qd[LAT-1];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  task automatic chk(string n, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, got, exp);
  endtask

  // Reference model state
  logic [DW-1:0] shadow [int];
  typedef struct { int who; logic [DW-1:0] d; int due; } rd_t;
  rd_t sbq [$];
  int            last_winner = 1;
  logic [AW-1:0] ea = '0;
  logic [DW-1:0] ed = '0;
  logic          ew = 1'b0;
  logic          g0 = 1'b0, g1 = 1'b0;

  function automatic logic [DW-1:0] mval(int a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  // Monitor: pops the scoreboard whenever a read return appears
  always @(negedge clock) begin
    if (r0_rvalid || r1_rvalid) begin
      chk("rvalid_exclusive", {62'd0, r0_rvalid, r1_rvalid}, {62'd0, r0_rvalid, ~r0_rvalid});
      if (sbq.size() == 0) begin
        chk("unexpected_rvalid", {62'd0, r0_rvalid, r1_rvalid}, 64'd0);
      end else begin
        rd_t e;
        e = sbq.pop_front();
        chk("rvalid_owner", 64'(r1_rvalid), 64'(e.who));
        chk("rvalid_cycle", 64'(cyc), 64'(e.due));
        chk("rdata", r1_rvalid ? 64'(r1_rdata) : 64'(r0_rdata), 64'(e.d));
      end
    end else begin
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        chk("missing_rvalid", 64'(sbq[0].due), 64'(-1));
        void'(sbq.pop_front());
      end
    end
  end

  task automatic step(int p, bit rst_low);
    bit both, eg0, eg1;
    @(posedge clock);
    #1;
    if (rst_low) begin
      reset = 1'b0;
      sbq.delete();
    end else begin
      reset = 1'b1;
      if (!r0_req || g0) begin
        r0_req   = $urandom_range(99) < p;
        r0_wren  = $urandom_range(9) < 4;
        r0_addr  = AW'($urandom_range(31));
        r0_wdata = $urandom;
      end else if (p < 100 && $urandom_range(19) == 0) begin
        r0_req = 1'b0;
      end
      if (!r1_req || g1) begin
        r1_req   = $urandom_range(99) < p;
        r1_wren  = $urandom_range(9) < 4;
        r1_addr  = AW'($urandom_range(31));
        r1_wdata = $urandom;
      end else if (p < 100 && $urandom_range(19) == 0) begin
        r1_req = 1'b0;
      end
    end
    @(negedge clock);
    if (rst_low) begin
      chk("rst_gnt", {62'd0, r0_gnt, r1_gnt}, 64'd0);
      chk("rst_issue", {wren, 20'd0, address_dmem, data}, 64'd0);
      chk("rst_rvalid", {62'd0, r0_rvalid, r1_rvalid}, 64'd0);
      last_winner = 1;
      ea = '0; ed = '0; ew = 1'b0;
      g0 = 1'b0; g1 = 1'b0;
      return;
    end
    chk("address_dmem", 64'(address_dmem), 64'(ea));
    chk("data", 64'(data), 64'(ed));
    chk("wren", 64'(wren), 64'(ew));
    both = r0_req && r1_req;
    eg0 = r0_req && !r1_req;
    eg1 = r1_req && !r0_req;
    if (both) begin
`ifdef DMEM_ARB_RR_EN
      if (last_winner == 0) eg1 = 1'b1;
      else eg0 = 1'b1;
`else
      eg0 = 1'b1;
`endif
    end
    chk("r0_gnt", 64'(r0_gnt), 64'(eg0));
    chk("r1_gnt", 64'(r1_gnt), 64'(eg1));
    g0 = eg0;
    g1 = eg1;
    ew = 1'b0;
    if (eg0 || eg1) begin
      int a;
      logic wr;
      logic [DW-1:0] wd;
      a  = int'(eg0 ? r0_addr : r1_addr);
      wr = eg0 ? r0_wren : r1_wren;
      wd = eg0 ? r0_wdata : r1_wdata;
      last_winner = eg1 ? 1 : 0;
      ea = AW'(a);
      ed = wd;
      ew = wr;
      if (wr) shadow[a] = wd;
      else sbq.push_back('{who: eg1 ? 1 : 0, d: mval(a), due: cyc + 1 + LAT});
    end
  endtask

  initial begin
    step(0, 1);
    step(0, 1);
    repeat (12)  step(100, 0);
    repeat (12)  step(0, 0);
    repeat (300) step(60, 0);
    repeat (4)   step(100, 0);
    step(100, 1);
    repeat (8)   step(100, 0);
    repeat (200) step(30, 0);
    repeat (3)   step(90, 0);
    step(90, 1);
    repeat (100) step(50, 0);
    repeat (12)  step(0, 0);
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
